// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: sequences a PC through a combinational instruction
// memory into a valid/ready instruction register, with redirect, halt word and restart.
module instr_fetch_ctrl #(
    parameter int                ADDR_W    = 5,
    parameter int                INST_W    = 13,
    parameter logic [INST_W-1:0] HALT_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_data,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic [INST_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              busy,
    output logic              halted,
    output logic [7:0]        fetch_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic [ADDR_W-1:0] ir_pc_nxt;
    logic [INST_W-1:0] ir_nxt;
    logic              ir_valid_nxt;
    logic [7:0]        cnt_nxt;
    logic              slot_free;
    logic              is_halt;

    // The register may take a new instruction when empty or when it is being consumed.
    assign slot_free = !ir_valid || ir_ready;
    assign is_halt   = (imem_data == HALT_WORD);

    always_comb begin
        // NOTE: every output of this block gets a hold value first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_nxt    = state;
        pc_nxt       = pc;
        ir_nxt       = ir;
        ir_pc_nxt    = ir_pc;
        ir_valid_nxt = ir_valid;
        cnt_nxt      = fetch_cnt;

        case (state)
            IDLE, HALT: begin
                if (start) begin
                    pc_nxt       = start_addr;
                    ir_valid_nxt = 1'b0;
                    cnt_nxt      = 8'd0;
                    state_nxt    = RUN;
                end
            end

            RUN: begin
                if (jump_valid) begin
                    // Redirect flushes the register, even if it is being accepted now.
                    pc_nxt       = jump_addr;
                    ir_valid_nxt = 1'b0;
                end else if (slot_free) begin
                    if (is_halt) begin
                        ir_valid_nxt = 1'b0;
                        state_nxt    = HALT;
                    end else begin
                        ir_nxt       = imem_data;
                        ir_pc_nxt    = pc;
                        ir_valid_nxt = 1'b1;
                        pc_nxt       = pc + ADDR_W'(1);
                        cnt_nxt      = (fetch_cnt == 8'hff) ? fetch_cnt : fetch_cnt + 8'd1;
                    end
                end
            end

            default: begin
                state_nxt    = IDLE;
                ir_valid_nxt = 1'b0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= '0;
            ir        <= '0;
            ir_pc     <= '0;
            ir_valid  <= 1'b0;
            fetch_cnt <= 8'd0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            ir        <= ir_nxt;
            ir_pc     <= ir_pc_nxt;
            ir_valid  <= ir_valid_nxt;
            fetch_cnt <= cnt_nxt;
        end
    end

    assign imem_addr = pc;
    assign busy      = (state == RUN);
    assign halted    = (state == HALT);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios plus randomized traffic,
// all checked against a stream-level reference model of the fetch controller.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  start_addr;
    logic [4:0]  imem_addr;
    logic [12:0] imem_data;
    logic        ir_valid;
    logic        ir_ready;
    logic [12:0] ir;
    logic [4:0]  ir_pc;
    logic        jump_valid;
    logic [4:0]  jump_addr;
    logic        busy;
    logic        halted;
    logic [7:0]  fetch_cnt;

    // Second instance with an all-ones halt word, used for the address wrap case.
    logic        w_start;
    logic [4:0]  w_start_addr;
    logic [4:0]  w_imem_addr;
    logic [12:0] w_imem_data;
    logic        w_ir_valid;
    logic        w_ir_ready;
    logic [12:0] w_ir;
    logic [4:0]  w_ir_pc;
    logic        w_jump_valid;
    logic [4:0]  w_jump_addr;
    logic        w_busy;
    logic        w_halted;
    logic [7:0]  w_fetch_cnt;

    logic [12:0] mem [32];

    assign imem_data   = mem[imem_addr];
    assign w_imem_data = mem[w_imem_addr];

    always #5 clk = ~clk;

    instr_fetch_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .ir_pc(ir_pc),
        .jump_valid(jump_valid), .jump_addr(jump_addr),
        .busy(busy), .halted(halted), .fetch_cnt(fetch_cnt)
    );

    instr_fetch_ctrl #(.HALT_WORD(13'h1fff)) dut_wrap (
        .clk(clk), .rst(rst), .start(w_start), .start_addr(w_start_addr),
        .imem_addr(w_imem_addr), .imem_data(w_imem_data),
        .ir_valid(w_ir_valid), .ir_ready(w_ir_ready), .ir(w_ir), .ir_pc(w_ir_pc),
        .jump_valid(w_jump_valid), .jump_addr(w_jump_addr),
        .busy(w_busy), .halted(w_halted), .fetch_cnt(w_fetch_cnt)
    );

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: the consumer sees the memory stream from the last start/jump
    // address onward, one word per free slot, ending before the first halt word.
    bit          m_active;
    bit          m_halted;
    logic [4:0]  m_addr;
    bit          m_valid;
    logic [12:0] m_ir;
    logic [4:0]  m_ir_pc;
    int          m_cnt;

    function automatic void model_reset();
        m_active = 0; m_halted = 0; m_addr = '0;
        m_valid  = 0; m_ir = '0; m_ir_pc = '0; m_cnt = 0;
    endfunction

    function automatic void model_edge(input bit s, input logic [4:0] sa, input bit r,
                                       input bit j, input logic [4:0] ja);
        if (!m_active) begin
            if (s) begin
                m_active = 1; m_halted = 0; m_addr = sa; m_valid = 0; m_cnt = 0;
            end
        end else if (j) begin
            m_addr = ja; m_valid = 0;
        end else if (!m_valid || r) begin
            if (mem[m_addr] == 13'h0000) begin
                m_valid = 0; m_active = 0; m_halted = 1;
            end else begin
                m_ir    = mem[m_addr];
                m_ir_pc = m_addr;
                m_valid = 1;
                m_addr  = 5'((int'(m_addr) + 1) % 32);
                m_cnt   = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
            end
        end
    endfunction

    task automatic compare(input string tag);
        check({tag, ".busy"},      32'(busy),      32'(m_active));
        check({tag, ".halted"},    32'(halted),    32'(m_halted));
        check({tag, ".imem_addr"}, 32'(imem_addr), 32'(m_addr));
        check({tag, ".ir_valid"},  32'(ir_valid),  32'(m_valid));
        check({tag, ".ir"},        32'(ir),        32'(m_ir));
        check({tag, ".ir_pc"},     32'(ir_pc),     32'(m_ir_pc));
        check({tag, ".fetch_cnt"}, 32'(fetch_cnt), m_cnt);
    endtask

    // Called at a falling edge: drive inputs, advance model, clock, then compare.
    task automatic cycle(input string tag, input bit s, input logic [4:0] sa, input bit r,
                         input bit j, input logic [4:0] ja);
        start = s; start_addr = sa; ir_ready = r; jump_valid = j; jump_addr = ja;
        model_edge(s, sa, r, j, ja);
        @(posedge clk);
        @(negedge clk);
        compare(tag);
    endtask

    // Reset pulse placed entirely between two rising edges.
    task automatic async_reset(input string tag);
        #2 rst = 1'b1;
        #1;
        check({tag, ".ir_valid"},  32'(ir_valid),  32'd0);
        check({tag, ".imem_addr"}, 32'(imem_addr), 32'd0);
        check({tag, ".busy"},      32'(busy),      32'd0);
        model_reset();
        #1 rst = 1'b0;
        @(negedge clk);
        compare({tag, ".after"});
    endtask

    task automatic load_program();
        for (int i = 0; i < 32; i++) mem[i] = 13'(16'h0100 + i);
        for (int i = 0; i < 8; i++) mem[i] = 13'(16'h1c00 + 16'h0011 * i);
        mem[8]  = 13'h0208;
        mem[20] = 13'h1b04;
        mem[21] = 13'h1e08;
        mem[29] = 13'h0000;
    endtask

    initial begin
        rst = 1'b1;
        start = 0; start_addr = '0; ir_ready = 0; jump_valid = 0; jump_addr = '0;
        w_start = 0; w_start_addr = '0; w_ir_ready = 0; w_jump_valid = 0; w_jump_addr = '0;
        load_program();
        model_reset();
        repeat (2) @(negedge clk);
        compare("reset");
        rst = 1'b0;
        cycle("idle", 0, 5'd0, 1, 1, 5'd7);

        // Straight-line program run to the halt word at 29.
        cycle("p_start", 1, 5'd0, 1, 0, 5'd0);
        cycle("p_first", 0, 5'd0, 1, 0, 5'd0);
        check("p_first_ir", 32'(ir), 32'h1c00);
        check("p_first_pc", 32'(ir_pc), 32'd0);
        cycle("p_second", 0, 5'd0, 1, 0, 5'd0);
        check("p_second_ir", 32'(ir), 32'h1c11);
        for (int i = 0; i < 40 && !m_halted; i++) cycle("p_run", 0, 5'd0, 1, 0, 5'd0);
        check("p_halted", 32'(halted), 32'd1);
        check("p_cnt", 32'(fetch_cnt), 32'd29);
        check("p_addr", 32'(imem_addr), 32'd29);
        check("p_last_pc", 32'(ir_pc), 32'd28);

        // Jump ignored in HALT, then restart at 8.
        cycle("h_jump", 0, 5'd0, 1, 1, 5'd5);
        check("h_jump_addr", 32'(imem_addr), 32'd29);
        check("h_jump_halted", 32'(halted), 32'd1);
        cycle("h_start", 1, 5'd8, 1, 0, 5'd0);
        cycle("h_first", 0, 5'd0, 1, 0, 5'd0);
        check("h_ir", 32'(ir), 32'h0208);
        check("h_pc", 32'(ir_pc), 32'd8);
        check("h_cnt", 32'(fetch_cnt), 32'd1);

        // Backpressure: consumer stalls for four cycles after the first valid.
        async_reset("rst1");
        cycle("bp_start", 1, 5'd0, 0, 0, 5'd0);
        cycle("bp_first", 0, 5'd0, 0, 0, 5'd0);
        for (int i = 0; i < 4; i++) begin
            cycle("bp_stall", 0, 5'd0, 0, 0, 5'd0);
            check("bp_ir", 32'(ir), 32'h1c00);
            check("bp_pc", 32'(ir_pc), 32'd0);
            check("bp_addr", 32'(imem_addr), 32'd1);
        end
        cycle("bp_go", 0, 5'd0, 1, 0, 5'd0);
        check("bp_next_ir", 32'(ir), 32'h1c11);

        // Jump from ir_pc 3 to 20.
        for (int i = 0; i < 10 && !(m_valid && m_ir_pc == 5'd3); i++)
            cycle("j_run", 0, 5'd0, 1, 0, 5'd0);
        check("j_at3", 32'(ir_pc), 32'd3);
        cycle("j_jump", 0, 5'd0, 1, 1, 5'd20);
        check("j_flush", 32'(ir_valid), 32'd0);
        cycle("j_t1", 0, 5'd0, 1, 0, 5'd0);
        check("j_t1_ir", 32'(ir), 32'h1b04);
        check("j_t1_pc", 32'(ir_pc), 32'd20);
        cycle("j_t2", 0, 5'd0, 1, 0, 5'd0);
        check("j_t2_ir", 32'(ir), 32'h1e08);
        check("j_t2_pc", 32'(ir_pc), 32'd21);

        // Asynchronous reset mid-run at ir_pc 10, then no output until start.
        cycle("r_jump", 0, 5'd0, 1, 1, 5'd8);
        for (int i = 0; i < 10 && !(m_valid && m_ir_pc == 5'd10); i++)
            cycle("r_run", 0, 5'd0, 1, 0, 5'd0);
        check("r_at10", 32'(ir_pc), 32'd10);
        async_reset("rst2");
        for (int i = 0; i < 3; i++) cycle("r_idle", 0, 5'd0, 1, 1, 5'd3);
        check("r_idle_valid", 32'(ir_valid), 32'd0);

        // Counter saturation with a memory that never halts.
        for (int i = 0; i < 32; i++) mem[i] = 13'(16'h0100 + i);
        cycle("s_start", 1, 5'd0, 1, 0, 5'd0);
        for (int i = 0; i < 300; i++) cycle("s_run", 0, 5'd0, 1, 0, 5'd0);
        check("s_cnt", 32'(fetch_cnt), 32'd255);

        // Randomized traffic, memory refreshed periodically with sparse halt words.
        for (int n = 0; n < 2000; n++) begin
            if (n % 250 == 0)
                for (int i = 0; i < 32; i++)
                    mem[i] = ($urandom_range(0, 11) == 0) ? 13'h0000
                                                          : 13'($urandom_range(1, 13'h1ffe));
            cycle("rnd", $urandom_range(0, 14) == 0, 5'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 5'($urandom));
        end

        // Address wrap on the instance whose halt word never occurs in memory.
        w_start = 1; w_start_addr = 5'd30; w_ir_ready = 1;
        @(posedge clk); @(negedge clk);
        w_start = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); @(negedge clk);
            check("w_valid", 32'(w_ir_valid), 32'd1);
            check("w_pc", 32'(w_ir_pc), 32'((30 + k) % 32));
            check("w_halted", 32'(w_halted), 32'd0);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, instruction-memory address width (32 words).
REQ-002 SHALL have parameter INST_W, default 13, instruction width.
REQ-003 SHALL have parameter HALT_WORD, default 13'h0000, fetched value that stops sequencing.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port start  input  1  begin fetching at start_addr.
REQ-007 SHALL have port start_addr  input  ADDR_W  first fetch address.
REQ-008 SHALL have port imem_addr  output  ADDR_W  read address to instruction memory; equals the PC register, no combinational path from inputs.
REQ-009 SHALL have port imem_data  input  INST_W  combinational read data for imem_addr.
REQ-010 SHALL have port ir_valid  output  1  ir/ir_pc hold a fetched instruction.
REQ-011 SHALL have port ir_ready  input  1  consumer accepts ir this cycle.
REQ-012 SHALL have port ir  output  INST_W  fetched instruction register.
REQ-013 SHALL have port ir_pc  output  ADDR_W  address ir was fetched from.
REQ-014 SHALL have port jump_valid  input  1  redirect request.
REQ-015 SHALL have port jump_addr  input  ADDR_W  redirect target.
REQ-016 SHALL have port busy  output  1  high in RUN.
REQ-017 SHALL have port halted  output  1  high in HALT.
REQ-018 SHALL have port fetch_cnt  output  8  instructions presented since last start, saturating at 255.

Function
REQ-019 SHALL implement states IDLE, RUN, HALT; busy = (state==RUN), halted = (state==HALT).
REQ-020 IDLE/HALT: start=1 -> pc<=start_addr, ir_valid<=0, fetch_cnt<=0, state<=RUN; start ignored in RUN.
REQ-021 RUN, slot free (ir_valid==0 or ir_ready==1), no jump: if imem_data!=HALT_WORD -> ir<=imem_data, ir_pc<=pc, ir_valid<=1, pc<=pc+1, fetch_cnt<=sat(fetch_cnt+1).
REQ-022 RUN, slot free, imem_data==HALT_WORD, no jump: ir_valid<=0, pc holds halt address, state<=HALT; halt word never presented.
REQ-023 RUN, slot occupied (ir_valid=1, ir_ready=0): ir, ir_pc, ir_valid, pc, fetch_cnt SHALL hold.
REQ-024 RUN, jump_valid=1: pc<=jump_addr, ir_valid<=0 (flush, pending ir dropped even if ir_ready=1), no fetch that cycle; jump wins over fetch and halt detection.
REQ-025 jump_valid SHALL be ignored in IDLE and HALT.
REQ-026 Latency: start or jump at edge N -> first instruction from new address with ir_valid=1 after edge N+1.
REQ-027 Throughput: with ir_ready held 1, one instruction per cycle.
REQ-028 PC arithmetic modulo 2^ADDR_W: 31+1 -> 0 (wrap, no halt, no flag).
REQ-029 fetch_cnt at 255 SHALL stay 255.
REQ-030 A handshake (ir_valid&&ir_ready) in the cycle the controller enters HALT completes normally; ir_valid is 0 afterwards.

Reset
REQ-031 rst=1 SHALL immediately force state=IDLE, pc=0, ir=0, ir_pc=0, ir_valid=0, fetch_cnt=0; busy=0, halted=0, imem_addr=0.
REQ-032 Reset asserted mid-RUN SHALL abort the fetch without presenting further instructions; after release the block waits in IDLE for start.

Verification
REQ-033 Program 0x1c00,0x1c11,...,0x1c77 at 0-7, word 29 = 0x0000; start, start_addr=0, ir_ready=1 -> ir 0x1c00 (ir_pc 0), 0x1c11 (ir_pc 1)... last ir_pc 28, then halted=1, fetch_cnt=29, imem_addr=29.
REQ-034 Start at 0, ir_ready=0 for 4 cycles after first valid -> ir=0x1c00, ir_pc=0 stable, imem_addr=1 stable; ir_ready=1 -> next ir 0x1c11.
REQ-035 In RUN at ir_pc 3, jump_valid=1, jump_addr=20 -> ir_valid=0 one cycle, then ir=0x1b04, ir_pc=20, then 0x1e08 at 21.
REQ-036 HALT_WORD=13'h1fff, start_addr=30 -> ir_pc sequence 30, 31, 0, 1; halted stays 0.
REQ-037 rst pulsed asynchronously (between edges) while RUN at ir_pc 10 -> ir_valid=0, imem_addr=0, busy=0 before next edge; no ir_valid until start.
REQ-038 In HALT, jump_valid=1 -> no change; then start, start_addr=8 -> ir=0x0208, ir_pc=8, fetch_cnt=1.
